grf_hazard_ctrl: RTL and testbench

Write-side tracker for the general register file in the five-stage MIPS pipeline. It records the destination register and remaining result latency (Tnew) of every instruction in flight in E, M and W. For the two source registers read in D, it decides whether D must stall or which stage the D-stage operand must be forwarded from. It is the producer-side counterpart of the GRF read path: the GRF bypasses W-stage writes, and this block covers everything younger.

---
 rtl/grf_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_grf_hazard_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/grf_hazard_ctrl.sv
// Producer-side hazard tracker for the GRF: records destination and Tnew for E/M/W and
// resolves stall / forward selection for the two D-stage source operands.
module grf_hazard_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       d_valid,
   input  logic [4:0] d_a3,
   input  logic [1:0] d_tnew,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic       d_rs_use,
   input  logic       d_rt_use,
   input  logic [1:0] d_rs_tuse,
   input  logic [1:0] d_rt_tuse,
   output logic       stall,
   output logic [1:0] fwd_rs_sel,
   output logic [1:0] fwd_rt_sel,
   output logic [4:0] e_a3,
   output logic [4:0] m_a3,
   output logic [4:0] w_a3
);

   localparam logic [1:0] SelGrf = 2'b00;
   localparam logic [1:0] SelE   = 2'b01;
   localparam logic [1:0] SelM   = 2'b10;

   logic       e_valid_q, e_valid_d;
   logic [4:0] e_a3_q, e_a3_d;
   logic [1:0] e_tnew_q, e_tnew_d;
   logic       m_valid_q, m_valid_d;
   logic [4:0] m_a3_q, m_a3_d;
   logic [1:0] m_tnew_q, m_tnew_d;
   // W results reach D through the GRF bypass, so only its destination is kept.
   logic [4:0] w_a3_q, w_a3_d;

   logic       stall_rs, stall_rt;

   // Returns {stall, sel[1:0]} for one source, looking only at its youngest match.
   function automatic logic [2:0] resolve(
      input logic [4:0] src,
      input logic       src_use,
      input logic [1:0] tuse,
      input logic       ev,
      input logic [4:0] ea3,
      input logic [1:0] etn,
      input logic       mv,
      input logic [4:0] ma3,
      input logic [1:0] mtn
   );
      logic       live;
      logic       st;
      logic [1:0] sel;
      live = src_use && (src != 5'd0);
      st   = 1'b0;
      sel  = SelGrf;
      if (live && ev && (ea3 == src)) begin
         st  = (etn > tuse);
         sel = (etn == 2'd0) ? SelE : SelGrf;
      end else if (live && mv && (ma3 == src)) begin
         st  = (mtn > tuse);
         sel = (mtn == 2'd0) ? SelM : SelGrf;
      end
      return {st, sel};
   endfunction

   always_comb begin
      {stall_rs, fwd_rs_sel} = resolve(d_rs, d_rs_use, d_rs_tuse, e_valid_q, e_a3_q, e_tnew_q,
                                       m_valid_q, m_a3_q, m_tnew_q);
      {stall_rt, fwd_rt_sel} = resolve(d_rt, d_rt_use, d_rt_tuse, e_valid_q, e_a3_q, e_tnew_q,
                                       m_valid_q, m_a3_q, m_tnew_q);
      stall = stall_rs | stall_rt;
   end

   always_comb begin
      w_a3_d    = m_a3_q;
      m_valid_d = e_valid_q;
      m_a3_d    = e_a3_q;
      m_tnew_d  = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
      e_valid_d = 1'b0;
      e_a3_d    = 5'd0;
      e_tnew_d  = 2'd0;
      if (d_valid && !stall) begin
         e_valid_d = 1'b1;
         e_a3_d    = d_a3;
         e_tnew_d  = d_tnew;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_valid_q <= 1'b0;
         e_a3_q    <= 5'd0;
         e_tnew_q  <= 2'd0;
         m_valid_q <= 1'b0;
         m_a3_q    <= 5'd0;
         m_tnew_q  <= 2'd0;
         w_a3_q    <= 5'd0;
      end else begin
         e_valid_q <= e_valid_d;
         e_a3_q    <= e_a3_d;
         e_tnew_q  <= e_tnew_d;
         m_valid_q <= m_valid_d;
         m_a3_q    <= m_a3_d;
         m_tnew_q  <= m_tnew_d;
         w_a3_q    <= w_a3_d;
      end
   end

   assign e_a3 = e_a3_q;
   assign m_a3 = m_a3_q;
   assign w_a3 = w_a3_q;

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Directed bench for grf_hazard_ctrl: expected outputs are queued with each D step and
// compared at the following falling edge.
module tb_grf_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       d_valid;
   logic [4:0] d_a3;
   logic [1:0] d_tnew;
   logic [4:0] d_rs, d_rt;
   logic       d_rs_use, d_rt_use;
   logic [1:0] d_rs_tuse, d_rt_tuse;
   logic       stall;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;
   logic [4:0] e_a3, m_a3, w_a3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic       stall;
      logic [1:0] fs;
      logic [1:0] ft;
      logic [4:0] ea;
      logic [4:0] ma;
      logic [4:0] wa;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   grf_hazard_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .d_valid    (d_valid),
      .d_a3       (d_a3),
      .d_tnew     (d_tnew),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_rs_use   (d_rs_use),
      .d_rt_use   (d_rt_use),
      .d_rs_tuse  (d_rs_tuse),
      .d_rt_tuse  (d_rt_tuse),
      .stall      (stall),
      .fwd_rs_sel (fwd_rs_sel),
      .fwd_rt_sel (fwd_rt_sel),
      .e_a3       (e_a3),
      .m_a3       (m_a3),
      .w_a3       (w_a3)
   );

   task automatic cmp(input string tag, input string fld, input logic [4:0] obs,
                      input logic [4:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s.%s observed %0h expected %0h", tag, fld, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive D, queue the expected response, then compare at the falling edge.
   task automatic step(input string tag,
                       input logic v, input logic [4:0] a3, input logic [1:0] tn,
                       input logic [4:0] rs, input logic rsu, input logic [1:0] rst,
                       input logic [4:0] rt, input logic rtu, input logic [1:0] rtt,
                       input logic es, input logic [1:0] efs, input logic [1:0] eft,
                       input logic [4:0] eea, input logic [4:0] ema, input logic [4:0] ewa);
      exp_t e;
      d_valid = v;   d_a3 = a3;    d_tnew = tn;
      d_rs = rs;     d_rs_use = rsu; d_rs_tuse = rst;
      d_rt = rt;     d_rt_use = rtu; d_rt_tuse = rtt;
      e.tag = tag; e.stall = es; e.fs = efs; e.ft = eft; e.ea = eea; e.ma = ema; e.wa = ewa;
      sb.push_back(e);
      @(negedge clk);
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL %s scoreboard observed empty expected entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         cmp(e.tag, "stall", {4'd0, stall}, {4'd0, e.stall});
         cmp(e.tag, "fwd_rs", {3'd0, fwd_rs_sel}, {3'd0, e.fs});
         cmp(e.tag, "fwd_rt", {3'd0, fwd_rt_sel}, {3'd0, e.ft});
         cmp(e.tag, "e_a3", e_a3, e.ea);
         cmp(e.tag, "m_a3", m_a3, e.ma);
         cmp(e.tag, "w_a3", w_a3, e.wa);
      end
   endtask

   initial begin
      reset = 1'b1;
      d_valid = 1'b1; d_a3 = 5'd5; d_tnew = 2'd2;
      d_rs = 5'd5; d_rs_use = 1'b1; d_rs_tuse = 2'd0;
      d_rt = 5'd0; d_rt_use = 1'b0; d_rt_tuse = 2'd0;
      tick();
      reset = 1'b0;
      //    tag           v  a3  tn  rs u tu  rt u tu   st fs     ft     e   m   w
      step("reset",      0, 5,  2,  5, 1, 0,  0, 0, 0,  0, 2'b00, 2'b00, 0,  0,  0);  tick();
      step("alu_issue",  1, 8,  1,  0, 0, 0,  0, 0, 0,  0, 2'b00, 2'b00, 0,  0,  0);  tick();
      step("alu_stall",  1, 10, 1,  8, 1, 0,  0, 0, 0,  1, 2'b00, 2'b00, 8,  0,  0);  tick();
      step("alu_fwd_m",  1, 10, 1,  8, 1, 0,  0, 0, 0,  0, 2'b10, 2'b00, 0,  8,  0);  tick();
      step("lw_issue",   1, 9,  2,  0, 0, 0,  0, 0, 0,  0, 2'b00, 2'b00, 10, 0,  8);  tick();
      step("lw_stall",   1, 11, 1,  0, 0, 0,  9, 1, 1,  1, 2'b00, 2'b00, 9,  10, 0);  tick();
      step("lw_release", 1, 11, 1,  0, 0, 0,  9, 1, 1,  0, 2'b00, 2'b00, 0,  9,  10); tick();
      step("lw_in_w",    0, 0,  0,  0, 0, 0,  0, 0, 0,  0, 2'b00, 2'b00, 11, 0,  9);  tick();
      step("zero_issue", 1, 0,  2,  0, 0, 0,  0, 0, 0,  0, 2'b00, 2'b00, 0,  11, 0);  tick();
      step("zero_read",  1, 4,  2,  0, 1, 0,  0, 0, 0,  0, 2'b00, 2'b00, 0,  0,  11); tick();
      step("no_use",     1, 0,  0,  4, 0, 0,  0, 0, 0,  0, 2'b00, 2'b00, 4,  0,  0);  tick();
      step("prio_fill1", 1, 4,  0,  0, 0, 0,  0, 0, 0,  0, 2'b00, 2'b00, 0,  4,  0);  tick();
      step("prio_fill2", 1, 4,  0,  0, 0, 0,  0, 0, 0,  0, 2'b00, 2'b00, 4,  0,  4);  tick();
      step("prio_fwd_e", 1, 4,  1,  4, 1, 0,  0, 0, 0,  0, 2'b01, 2'b00, 4,  4,  0);  tick();
      step("prio_stall", 0, 0,  0,  4, 1, 0,  0, 0, 0,  1, 2'b00, 2'b00, 4,  4,  4);  tick();
      step("dual_fill1", 1, 7,  0,  0, 0, 0,  0, 0, 0,  0, 2'b00, 2'b00, 0,  4,  4);  tick();
      step("dual_fill2", 1, 3,  0,  0, 0, 0,  0, 0, 0,  0, 2'b00, 2'b00, 7,  0,  4);  tick();
      step("dual_fwd",   0, 0,  0,  3, 1, 0,  7, 1, 0,  0, 2'b01, 2'b10, 3,  7,  0);  tick();
      step("tnew3_iss",  1, 12, 3,  0, 0, 0,  0, 0, 0,  0, 2'b00, 2'b00, 0,  3,  7);  tick();
      step("tnew3_e",    1, 13, 0,  12, 1, 0, 0, 0, 0,  1, 2'b00, 2'b00, 12, 0,  3);  tick();
      step("tnew3_m",    1, 13, 0,  12, 1, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0,  12, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      step("rst_mid",    1, 13, 0,  12, 1, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0,  0,  0);  tick();
      step("post_rst",   0, 0,  0,  13, 1, 0, 0, 0, 0,  0, 2'b01, 2'b00, 13, 0,  0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
